// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared board geometry, FSM state and cell-class types
// Contents:
//   BOARD_W, BOARD_H   playable board size in cells
//   X_W, Y_W           coordinate widths
//   state_e            collision checker FSM states
//   cell_class_e       per-cell placement classification
package tetris_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;
    localparam int X_W     = 4;
    localparam int Y_W     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FREE_ABOVE = 2'd0,
        OOB        = 2'd1,
        READ       = 2'd2
    } cell_class_e;

endpackage

// File: rtl/cell_classify.sv
// rtl/cell_classify.sv - combinational classification of one (x,y) board cell
// Ports:
//   i_x    in   X_W   cell column
//   i_y    in   Y_W   cell row; all-ones is row -1 (above the board)
//   o_cls  out  2     FREE_ABOVE, OOB (wall/floor) or READ (needs occupancy)
module cell_classify
    import tetris_pkg::*;
(
    input  logic [X_W-1:0] i_x,
    input  logic [Y_W-1:0] i_y,
    output cell_class_e    o_cls
);

    localparam logic [X_W-1:0] X_LIMIT = X_W'(BOARD_W);
    localparam logic [Y_W-1:0] Y_LIMIT = Y_W'(BOARD_H);
    localparam logic [Y_W-1:0] Y_ABOVE = '1;

    // The wall test comes first so a wrapped x (pivot 0 minus 1 = 15)
    // collides even when the cell is also above the board.
    always_comb begin
        o_cls = READ;
        if (i_x >= X_LIMIT) begin
            o_cls = OOB;
        end else if (i_y == Y_ABOVE) begin
            o_cls = FREE_ABOVE;
        end else if (i_y >= Y_LIMIT) begin
            o_cls = OOB;
        end
    end

endmodule

// File: rtl/collision_checker.sv
// rtl/collision_checker.sv - checks a 4-cell placement against walls, floor and locked cells
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req               start a check (only honoured in IDLE)
//   x1..x4, y1..y4    absolute cell coordinates, captured on accept
//   rd_en, rd_row     board RAM read strobe and row address
//   rd_data           row occupancy, valid the cycle after rd_en
//   busy              high from the cycle after accept through the done cycle
//   done              one-cycle pulse when collide is final
//   collide           sticky result, held until the next accepted req
module collision_checker
    import tetris_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic [X_W-1:0]     x1,
    input  logic [X_W-1:0]     x2,
    input  logic [X_W-1:0]     x3,
    input  logic [X_W-1:0]     x4,
    input  logic [Y_W-1:0]     y1,
    input  logic [Y_W-1:0]     y2,
    input  logic [Y_W-1:0]     y3,
    input  logic [Y_W-1:0]     y4,
    output logic               rd_en,
    output logic [Y_W-1:0]     rd_row,
    input  logic [BOARD_W-1:0] rd_data,
    output logic               busy,
    output logic               done,
    output logic               collide
);

    state_e             r_state;
    logic [2:0]         r_idx;
    logic [X_W-1:0]     r_x [0:3];
    logic [Y_W-1:0]     r_y [0:3];

    // Issue stage: aligned with rd_en/rd_row.
    logic               r_iss_vld;
    cell_class_e        r_iss_cls;
    logic [X_W-1:0]     r_iss_x;
    // Evaluate stage: aligned with rd_data.
    logic               r_ev_vld;
    cell_class_e        r_ev_cls;
    logic [X_W-1:0]     r_ev_x;

    logic               r_rd_en;
    logic [Y_W-1:0]     r_rd_row;
    logic               r_busy;
    logic               r_done;
    logic               r_collide;

    logic               w_accept;
    logic               w_issue;
    logic [1:0]         w_next_idx;
    logic [X_W-1:0]     w_sel_x;
    logic [Y_W-1:0]     w_sel_y;
    cell_class_e        w_cls;
    logic               w_hit;

    assign w_accept   = (r_state == IDLE) && req;
    // Cell 0 is issued straight from the inputs on the accept edge so
    // that rd_en is up in the first cycle after accept; cells 1..3 come
    // from the captured registers while idx runs 0..2.
    assign w_issue    = w_accept || ((r_state == RUN) && (r_idx < 3'd3));
    assign w_next_idx = r_idx[1:0] + 2'd1;
    assign w_sel_x    = w_accept ? x1 : r_x[w_next_idx];
    assign w_sel_y    = w_accept ? y1 : r_y[w_next_idx];

    cell_classify u_cell_classify (
        .i_x   (w_sel_x),
        .i_y   (w_sel_y),
        .o_cls (w_cls)
    );

    assign w_hit = r_ev_vld &&
                   ((r_ev_cls == OOB) || ((r_ev_cls == READ) && rd_data[r_ev_x]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            for (int i = 0; i < 4; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (req) begin
                        r_state <= RUN;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_x[0]  <= x1;
                        r_x[1]  <= x2;
                        r_x[2]  <= x3;
                        r_x[3]  <= x4;
                        r_y[0]  <= y1;
                        r_y[1]  <= y2;
                        r_y[2]  <= y3;
                        r_y[3]  <= y4;
                    end
                end
                RUN: begin
                    r_idx <= r_idx + 3'd1;
                    // idx 4 is the drain cycle for the last evaluation.
                    if (r_idx == 3'd4) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_vld <= 1'b0;
            r_iss_cls <= FREE_ABOVE;
            r_iss_x   <= '0;
            r_ev_vld  <= 1'b0;
            r_ev_cls  <= FREE_ABOVE;
            r_ev_x    <= '0;
            r_rd_en   <= 1'b0;
            r_rd_row  <= '0;
        end else begin
            r_iss_vld <= w_issue;
            r_iss_cls <= w_cls;
            r_iss_x   <= w_sel_x;
            r_rd_en   <= w_issue && (w_cls == READ);
            // rd_row only moves on a real read and otherwise holds.
            if (w_issue && (w_cls == READ)) begin
                r_rd_row <= w_sel_y;
            end
            r_ev_vld  <= r_iss_vld;
            r_ev_cls  <= r_iss_cls;
            r_ev_x    <= r_iss_x;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_collide <= 1'b0;
        end else if (w_accept) begin
            r_collide <= 1'b0;
        end else if (w_hit) begin
            r_collide <= 1'b1;
        end
    end

    assign rd_en   = r_rd_en;
    assign rd_row  = r_rd_row;
    assign busy    = r_busy;
    assign done    = r_done;
    assign collide = r_collide;

endmodule

// File: tb/tb_collision_checker.sv
// tb/tb_collision_checker.sv - table-driven bench for collision_checker
module tb_collision_checker;
    import tetris_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               req = 1'b0;
    logic [3:0]         x1 = '0, x2 = '0, x3 = '0, x4 = '0;
    logic [4:0]         y1 = '0, y2 = '0, y3 = '0, y4 = '0;
    logic               rd_en;
    logic [4:0]         rd_row;
    logic [9:0]         rd_data = '0;
    logic               busy;
    logic               done;
    logic               collide;

    logic [9:0]         board [0:19];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    collision_checker dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .x1      (x1),
        .x2      (x2),
        .x3      (x3),
        .x4      (x4),
        .y1      (y1),
        .y2      (y2),
        .y3      (y3),
        .y4      (y4),
        .rd_en   (rd_en),
        .rd_row  (rd_row),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .collide (collide)
    );

    // Board RAM model: 1-cycle latency; returns all-ones junk when no
    // read was issued so an unread cell that consults rd_data collides.
    always @(posedge clk) begin
        if (rd_en && rd_row < 5'd20) rd_data <= board[rd_row];
        else                         rd_data <= 10'h3FF;
    end

    typedef struct {
        logic [15:0] xs;     // {x1,x2,x3,x4}
        logic [19:0] ys;     // {y1,y2,y3,y4}
        logic [4:0]  brow;   // one occupied row to program
        logic [9:0]  bval;
        logic [3:0]  mask;   // expected rd_en, cell 0 is the MSB
        logic        exp_col;
    } vec_t;

    vec_t vecs [0:9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_cells(input logic [15:0] xs, input logic [19:0] ys);
        x1 = xs[15:12]; x2 = xs[11:8]; x3 = xs[7:4]; x4 = xs[3:0];
        y1 = ys[19:15]; y2 = ys[14:10]; y3 = ys[9:5]; y4 = ys[4:0];
    endtask

    task automatic load_board(input logic [4:0] row, input logic [9:0] val);
        for (int r = 0; r < 20; r++) board[r] = '0;
        board[row] = val;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        logic [4:0] yk;
        load_board(v.brow, v.bval);
        @(negedge clk);
        set_cells(v.xs, v.ys);
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            if (k <= 4) begin
                yk = v.ys[(4-k)*5 +: 5];
                chk($sformatf("v%0d rd_en c%0d", id, k-1), rd_en, v.mask[4-k]);
                if (v.mask[4-k]) chk($sformatf("v%0d rd_row c%0d", id, k-1), rd_row, yk);
            end
            chk($sformatf("v%0d busy T+%0d", id, k), busy, 1'b1);
            chk($sformatf("v%0d done T+%0d", id, k), done, (k == 6) ? 1'b1 : 1'b0);
            if (k == 6) chk($sformatf("v%0d collide", id), collide, v.exp_col);
        end
        @(posedge clk); #1;
        chk($sformatf("v%0d busy T+7", id), busy, 1'b0);
        chk($sformatf("v%0d done T+7", id), done, 1'b0);
        chk($sformatf("v%0d collide hold", id), collide, v.exp_col);
    endtask

    initial begin
        int ndone;
        int lat;

        vecs[0] = '{16'h4354, {5'd0, 5'd0, 5'd0, 5'd1},    5'd1,  10'b0000000000, 4'b1111, 1'b0};
        vecs[1] = '{16'h4354, {5'd0, 5'd0, 5'd0, 5'd1},    5'd1,  10'b0000010000, 4'b1111, 1'b1};
        vecs[2] = '{16'hF454, {5'd0, 5'd0, 5'd0, 5'd1},    5'd0,  10'b0000000000, 4'b0111, 1'b1};
        vecs[3] = '{16'h4453, {5'd19, 5'd20, 5'd19, 5'd19}, 5'd0, 10'b0000000000, 4'b1011, 1'b1};
        vecs[4] = '{16'h4453, {5'd31, 5'd0, 5'd0, 5'd0},   5'd0,  10'b0000000000, 4'b0111, 1'b0};
        vecs[5] = '{16'h9090, {5'd19, 5'd0, 5'd0, 5'd19},  5'd19, 10'b1000000000, 4'b1111, 1'b1};
        vecs[6] = '{16'h2222, {5'd5, 5'd5, 5'd5, 5'd5},    5'd5,  10'b0000000100, 4'b1111, 1'b1};
        vecs[7] = '{16'h2222, {5'd5, 5'd5, 5'd5, 5'd5},    5'd5,  10'b0000001000, 4'b1111, 1'b0};
        vecs[8] = '{16'hA012, {5'd0, 5'd0, 5'd0, 5'd0},    5'd0,  10'b0000000000, 4'b0111, 1'b1};
        vecs[9] = '{16'h0019, {5'd18, 5'd19, 5'd19, 5'd18}, 5'd18, 10'b0000000010, 4'b1111, 1'b0};

        load_board(5'd0, 10'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset rd_en", rd_en, 1'b0);
        chk("reset rd_row", rd_row, 5'd0);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset collide", collide, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
            if (i == 1) begin
                repeat (3) @(posedge clk);
                #1;
                chk("sticky collide", collide, 1'b1);
            end
        end

        // req during RUN and DONE is ignored; req at T+7 is accepted.
        run_vec(vecs[1], 100);
        load_board(vecs[1].brow, vecs[1].bval);
        @(negedge clk);
        set_cells(vecs[1].xs, vecs[1].ys);
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            req = 1'b0;
            if (done) ndone++;
            if (k == 2 || k == 6) begin
                set_cells(vecs[4].xs, vecs[4].ys);
                req = 1'b1;
            end
            if (k == 6) chk("ignored req collide", collide, 1'b1);
            if (k == 7) begin
                chk("ignored req busy T+7", busy, 1'b0);
                set_cells(vecs[4].xs, vecs[4].ys);
                req = 1'b1;
            end
        end
        chk("ignored req single done", ndone, 1);
        @(posedge clk); #1;
        req = 1'b0;
        chk("reaccept collide cleared", collide, 1'b0);
        chk("reaccept busy", busy, 1'b1);
        lat = 0;
        for (int k = 2; k <= 12 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (done) lat = k;
        end
        chk("reaccept latency", lat, 6);
        chk("reaccept collide", collide, 1'b0);

        // Asynchronous reset in the middle of a check.
        repeat (2) @(posedge clk);
        load_board(vecs[1].brow, vecs[1].bval);
        @(negedge clk);
        set_cells(vecs[1].xs, vecs[1].ys);
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre-reset busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async rst rd_en", rd_en, 1'b0);
        chk("async rst rd_row", rd_row, 5'd0);
        chk("async rst busy", busy, 1'b0);
        chk("async rst done", done, 1'b0);
        chk("async rst collide", collide, 1'b0);
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("no done after reset", ndone, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[0], 200);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
